// File: rtl/func_sweep_ctrl.sv
// Exhaustive-sweep controller: walks every input code, samples three function variants, accumulates results.
// Optional golden-table check enabled by defining FUNC_SWEEP_GOLDEN_EN.
module func_sweep_ctrl #(
  parameter int unsigned           N      = 4,
  parameter int unsigned           SETTLE = 1,
  parameter logic [(1<<N)-1:0]     GOLDEN = 16'h56E2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 out_g,
  input  logic                 out_d,
  input  logic                 out_b,
  output logic [N-1:0]         in_vec,
  output logic                 busy,
  output logic                 done,
  output logic [(1<<N)-1:0]    truth,
  output logic [(1<<N)-1:0]    mism,
  output logic [N:0]           err_cnt,
  output logic [N-1:0]         first_fail,
  output logic                 fail_vld,
  output logic                 res_vld
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned EW = N + 1;
  localparam int unsigned CW = 4;
  localparam logic [N-1:0] LAST_CODE = {N{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    in_vec_q, in_vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    truth_q, truth_d;
  logic [W-1:0]    mism_q, mism_d;
  logic [EW-1:0]   err_cnt_q, err_cnt_d;
  logic [N-1:0]    first_fail_q, first_fail_d;
  logic            fail_vld_q, fail_vld_d;
  logic            res_vld_q, res_vld_d;
  logic            fail_c;

  // A code fails when the variants disagree (and, optionally, when they miss the golden table)
`ifdef FUNC_SWEEP_GOLDEN_EN
  always_comb begin
    fail_c = !((out_g == out_d) && (out_d == out_b)) || (out_b != GOLDEN[in_vec_q]);
  end
`else
  logic unused_golden;
  assign unused_golden = ^GOLDEN;

  always_comb begin
    fail_c = !((out_g == out_d) && (out_d == out_b));
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      in_vec_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      truth_q      <= '0;
      mism_q       <= '0;
      err_cnt_q    <= '0;
      first_fail_q <= '0;
      fail_vld_q   <= 1'b0;
      res_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in_vec_q     <= in_vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      truth_q      <= truth_d;
      mism_q       <= mism_d;
      err_cnt_q    <= err_cnt_d;
      first_fail_q <= first_fail_d;
      fail_vld_q   <= fail_vld_d;
      res_vld_q    <= res_vld_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    in_vec_d     = in_vec_q;
    truth_d      = truth_q;
    mism_d       = mism_q;
    err_cnt_d    = err_cnt_q;
    first_fail_d = first_fail_q;
    fail_vld_d   = fail_vld_q;
    res_vld_d    = res_vld_q;

    if (abort) begin
      // Abort wins over everything; partial results are frozen, never marked valid
      state_d   = S_IDLE;
      res_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            truth_d      = '0;
            mism_d       = '0;
            err_cnt_d    = '0;
            first_fail_d = '0;
            fail_vld_d   = 1'b0;
            res_vld_d    = 1'b0;
            cnt_d        = CW'(SETTLE);
            state_d      = S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (cnt_q <= CW'(1)) begin
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_SAMPLE: begin
          truth_d[in_vec_q] = out_b;
          if (fail_c) begin
            mism_d[in_vec_q] = 1'b1;
            err_cnt_d        = err_cnt_q + EW'(1);
            if (!fail_vld_q) begin
              first_fail_d = in_vec_q;
              fail_vld_d   = 1'b1;
            end
          end
          if (in_vec_q == LAST_CODE) begin
            state_d = S_DONE;
          end else begin
            in_vec_d = in_vec_q + N'(1);
            cnt_d    = CW'(SETTLE);
            state_d  = S_DRIVE;
          end
        end
        S_DONE: begin
          res_vld_d = 1'b1;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_IDLE) begin
      in_vec_d = '0;
    end
    busy_d = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

  assign in_vec     = in_vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign truth      = truth_q;
  assign mism       = mism_q;
  assign err_cnt    = err_cnt_q;
  assign first_fail = first_fail_q;
  assign fail_vld   = fail_vld_q;
  assign res_vld    = res_vld_q;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Directed bench for func_sweep_ctrl: vector table of fault patterns plus reset/abort/settle sequences.
module tb_func_sweep_ctrl;

  logic clk = 1'b0;
  logic rst, start, abort, start2;
  logic [3:0]  in_vec, in_vec2, first_fail, first_fail2;
  logic        busy, done, fail_vld, res_vld, busy2, done2, fail_vld2, res_vld2;
  logic [15:0] truth, mism, truth2, mism2;
  logic [4:0]  err_cnt, err_cnt2;
  logic        out_g, out_d, out_b, f1;
  logic        out_g2, out_d2, out_b2;

  logic [15:0] gold = 16'h56E2;
  logic [15:0] g_zero, d_flip;
  logic        inv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural model of the three variants with injectable faults
  assign f1    = gold[in_vec] ^ inv;
  assign out_b = f1;
  assign out_g = g_zero[in_vec] ? 1'b0 : f1;
  assign out_d = f1 ^ d_flip[in_vec];

  assign out_b2 = gold[in_vec2];
  assign out_g2 = gold[in_vec2];
  assign out_d2 = gold[in_vec2];

  func_sweep_ctrl #(.N(4), .SETTLE(1), .GOLDEN(16'h56E2)) u1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .out_g(out_g), .out_d(out_d), .out_b(out_b),
    .in_vec(in_vec), .busy(busy), .done(done), .truth(truth), .mism(mism),
    .err_cnt(err_cnt), .first_fail(first_fail), .fail_vld(fail_vld), .res_vld(res_vld)
  );

  func_sweep_ctrl #(.N(4), .SETTLE(3), .GOLDEN(16'h56E2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
    .out_g(out_g2), .out_d(out_d2), .out_b(out_b2),
    .in_vec(in_vec2), .busy(busy2), .done(done2), .truth(truth2), .mism(mism2),
    .err_cnt(err_cnt2), .first_fail(first_fail2), .fail_vld(fail_vld2), .res_vld(res_vld2)
  );

  typedef struct {
    logic [15:0] gz;
    logic [15:0] df;
    logic        inv;
    logic [15:0] truth;
    logic [15:0] mism;
    logic [4:0]  err;
    logic [3:0]  ff;
    logic        fv;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start a sweep on u1 and return edges from T0 to done (-1 on timeout)
  task automatic sweep1(output int lat);
    int k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("in_vec_after_start", 64'(in_vec), 64'd0);
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    lat = (k >= 200) ? -1 : k;
  endtask

  task automatic wait_code(input logic [3:0] code);
    int k;
    k = 0;
    while (in_vec != code && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_code", 64'(in_vec), 64'(code));
  endtask

  task automatic no_done_window(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    g_zero = v.gz;
    d_flip = v.df;
    inv    = v.inv;
    sweep1(lat);
    chk("done_latency", 64'(lat), 64'd32);
    chk("truth", 64'(truth), 64'(v.truth));
    chk("mism", 64'(mism), 64'(v.mism));
    chk("err_cnt", 64'(err_cnt), 64'(v.err));
    chk("first_fail", 64'(first_fail), 64'(v.ff));
    chk("fail_vld", 64'(fail_vld), 64'(v.fv));
    chk("res_vld_during_done", 64'(res_vld), 64'd0);
    @(negedge clk);
    chk("post_done_state", 64'({done, busy, res_vld, in_vec}), 64'({1'b0, 1'b0, 1'b1, 4'd0}));
  endtask

  initial begin
    int lat;
    int k;
    int zero_cnt;

    vecs[0] = '{gz: 16'h0000, df: 16'h0000, inv: 1'b0, truth: 16'h56E2, mism: 16'h0000, err: 5'd0,  ff: 4'd0, fv: 1'b0};
    vecs[1] = '{gz: 16'h1040, df: 16'h0000, inv: 1'b0, truth: 16'h56E2, mism: 16'h1040, err: 5'd2,  ff: 4'd6, fv: 1'b1};
`ifdef FUNC_SWEEP_GOLDEN_EN
    vecs[2] = '{gz: 16'h0000, df: 16'h0000, inv: 1'b1, truth: 16'hA91D, mism: 16'hFFFF, err: 5'd16, ff: 4'd0, fv: 1'b1};
`else
    vecs[2] = '{gz: 16'h0000, df: 16'h0000, inv: 1'b1, truth: 16'hA91D, mism: 16'h0000, err: 5'd0,  ff: 4'd0, fv: 1'b0};
`endif
    vecs[3] = '{gz: 16'h0000, df: 16'h8001, inv: 1'b0, truth: 16'h56E2, mism: 16'h8001, err: 5'd2,  ff: 4'd0, fv: 1'b1};
    vecs[4] = '{gz: 16'h0000, df: 16'hFFFF, inv: 1'b0, truth: 16'h56E2, mism: 16'hFFFF, err: 5'd16, ff: 4'd0, fv: 1'b1};
    vecs[5] = '{gz: 16'h4000, df: 16'h0200, inv: 1'b0, truth: 16'h56E2, mism: 16'h4200, err: 5'd2,  ff: 4'd9, fv: 1'b1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0;
    g_zero = '0; d_flip = '0; inv = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_values",
        64'({busy, done, in_vec, truth, mism, err_cnt, first_fail, fail_vld, res_vld}), 64'd0);

    // Reset mid-sweep with a failure already recorded at code 0
    d_flip = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_code(4'd5);
    chk("pre_reset_fail_vld", 64'(fail_vld), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_clears",
        64'({busy, done, in_vec, truth, mism, err_cnt, first_fail, fail_vld, res_vld}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    no_done_window("no_done_after_reset");
    chk("idle_after_reset", 64'(busy), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end

    // Abort at code 9
    g_zero = '0; d_flip = '0; inv = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("res_vld_cleared_by_start", 64'(res_vld), 64'd0);
    wait_code(4'd9);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_state", 64'({busy, done, res_vld, in_vec}), 64'd0);
    no_done_window("no_done_after_abort");

    // Abort beats start in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", 64'(busy), 64'd0);

    run_vec(vecs[0]);

    // SETTLE=3: 4 cycles per code, done at T0+64, second start ignored
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    k = 0; zero_cnt = 0;
    while (!done2 && k < 300) begin
      if (in_vec2 == 4'd0) zero_cnt++;
      start2 = (k == 9);
      @(negedge clk);
      k++;
    end
    start2 = 1'b0;
    chk("settle3_hold_cycles", 64'(zero_cnt), 64'd4);
    chk("settle3_latency", 64'(k), 64'd64);
    chk("settle3_truth", 64'(truth2), 64'h56E2);
    chk("settle3_err", 64'(err_cnt2), 64'd0);
    @(negedge clk);
    chk("settle3_done_width", 64'({done2, res_vld2, busy2}), 64'({1'b0, 1'b1, 1'b0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
